// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Purpose: groups the three handshake groups around the unified memory port
// arbiter: the instruction-fetch requester, the data (load/store) requester and
// the shared memory port, plus the sticky error flag.
//
// Signal names are written from the arbiter's point of view (i_* flows into
// the arbiter, o_* flows out of it).
//
// Modports:
//   master - the arbiter itself (drives o_*, samples i_*)
//   slave  - the environment: requesters and memory (drives i_*, samples o_*)
//
// Handshake semantics (all signals synchronous to the arbiter clock):
//   * A requester raises *_req with its fields and holds all of them stable
//     until it sees its one-cycle *_gnt pulse. It may drop the request in the
//     cycle after the grant.
//   * The arbiter raises o_mem_req with stable o_mem_* fields until a cycle in
//     which i_mem_ready is high; that cycle is the acceptance cycle and the
//     winner's gnt pulses in that same cycle.
//   * For reads, memory later returns one i_mem_rvalid pulse with
//     i_mem_rdata; the arbiter forwards it as a one-cycle *_rvalid pulse to
//     the winner on the following cycle. Writes complete at acceptance.
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if;
    // Fetch requester
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        o_if_gnt;
    logic        o_if_rvalid;
    logic [31:0] o_if_rdata;

    // Data requester
    logic        i_d_req;
    logic [31:0] i_d_addr;
    logic        i_d_ren;
    logic        i_d_wen;
    logic [31:0] i_d_wdata;
    logic [3:0]  i_d_mask;
    logic        o_d_gnt;
    logic        o_d_rvalid;
    logic [31:0] o_d_rdata;

    // Shared memory port
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        o_mem_ren;
    logic        o_mem_wen;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_mask;
    logic        i_mem_ready;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;

    // Sticky error flag
    logic        o_err;

    modport master (
        input  i_if_req, i_if_addr,
        output o_if_gnt, o_if_rvalid, o_if_rdata,
        input  i_d_req, i_d_addr, i_d_ren, i_d_wen, i_d_wdata, i_d_mask,
        output o_d_gnt, o_d_rvalid, o_d_rdata,
        output o_mem_req, o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata, o_mem_mask,
        input  i_mem_ready, i_mem_rvalid, i_mem_rdata,
        output o_err
    );

    modport slave (
        output i_if_req, i_if_addr,
        input  o_if_gnt, o_if_rvalid, o_if_rdata,
        output i_d_req, i_d_addr, i_d_ren, i_d_wen, i_d_wdata, i_d_mask,
        input  o_d_gnt, o_d_rvalid, o_d_rdata,
        input  o_mem_req, o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata, o_mem_mask,
        output i_mem_ready, i_mem_rvalid, i_mem_rdata,
        input  o_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose: shares one multi-cycle memory port between the instruction-fetch
// requester and the data (load/store) requester. Exactly one transaction is in
// flight at a time. By default data wins over fetch, since the data request
// belongs to the older instruction.
//
// Ports:
//   i_clk        global clock
//   i_rst        synchronous active-high reset
//   bus          mem_port_arbiter_if.master: fetch, data and memory handshakes
//                and the sticky o_err flag (see the interface for semantics)
//   o_dbg_state  current FSM state (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//
// Parameters:
//   TIMEOUT      maximum cycles spent in WAIT before the read is abandoned and
//                o_err is set; 0 disables the timeout.
//
// Optional feature (compile-time macro ARB_ROUND_ROBIN_EN):
//   defined   - a last-winner register (reset: fetch) is updated on every
//               acceptance; when both requesters are high in IDLE, the one
//               that did not win last is chosen.
//   undefined - fixed data-over-fetch priority, no last-winner register.
//
// FSM:
//   IDLE  - arbitrate, latch the winner's fields into the memory-port registers
//   ISSUE - o_mem_req high until i_mem_ready; winner's gnt pulses that cycle;
//           writes return to IDLE, reads go to WAIT
//   WAIT  - wait for i_mem_rvalid (bounded by TIMEOUT)
//   RESP  - one-cycle rvalid pulse to the winner
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    mem_port_arbiter_if.master  bus,
    output logic [1:0]          o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Counter just wide enough to reach TIMEOUT-1.
    localparam int             CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t        r_state;
    logic          r_win_d;      // 1: current transaction belongs to data
    logic          r_mem_req;
    logic [31:0]   r_mem_addr;
    logic          r_mem_ren;
    logic          r_mem_wen;
    logic [31:0]   r_mem_wdata;
    logic [3:0]    r_mem_mask;
    logic          r_if_rvalid;
    logic [31:0]   r_if_rdata;
    logic          r_d_rvalid;
    logic [31:0]   r_d_rdata;
    logic          r_err;
    logic [CW-1:0] r_cnt;

`ifdef ARB_ROUND_ROBIN_EN
    logic          r_last_d;     // 1: data won the most recent acceptance
`endif

    logic          w_any_req;
    logic          w_pick_d;
    logic          w_d_bad;
    logic          w_accept;
    logic          w_unused;

    assign w_any_req = bus.i_d_req | bus.i_if_req;

`ifdef ARB_ROUND_ROBIN_EN
    // On a tie, hand the port to whoever did not win last time.
    assign w_pick_d = bus.i_d_req & (~bus.i_if_req | ~r_last_d);
`else
    assign w_pick_d = bus.i_d_req;
`endif

    // A data request must be exactly one of load or store.
    assign w_d_bad = (bus.i_d_ren == bus.i_d_wen);

    // Acceptance is the ISSUE cycle in which memory is ready. The grant is
    // combinational on i_mem_ready so the requester sees it in the very
    // cycle memory takes the request.
    assign w_accept = (r_state == S_ISSUE) & bus.i_mem_ready & ~i_rst;

    // Address byte offsets are dropped: the port is word addressed.
    assign w_unused = ^{bus.i_if_addr[1:0], bus.i_d_addr[1:0]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_win_d     <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_ren   <= 1'b0;
            r_mem_wen   <= 1'b0;
            r_mem_wdata <= '0;
            r_mem_mask  <= '0;
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rvalid  <= 1'b0;
            r_d_rdata   <= '0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_d    <= 1'b0;
`endif
        end else begin
            // rvalid pulses last exactly one cycle (the RESP cycle).
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;

            unique case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_win_d    <= w_pick_d;
                        r_mem_req  <= 1'b1;
                        r_state    <= S_ISSUE;
                        if (w_pick_d) begin
                            r_mem_addr  <= {bus.i_d_addr[31:2], 2'b00};
                            // A malformed request is serviced as a plain read
                            // so the requester always gets a response.
                            r_mem_ren   <= bus.i_d_ren | w_d_bad;
                            r_mem_wen   <= bus.i_d_wen & ~bus.i_d_ren;
                            r_mem_wdata <= bus.i_d_wdata;
                            r_mem_mask  <= bus.i_d_mask;
                            if (w_d_bad) begin
                                r_err <= 1'b1;
                            end
                        end else begin
                            r_mem_addr  <= {bus.i_if_addr[31:2], 2'b00};
                            r_mem_ren   <= 1'b1;
                            r_mem_wen   <= 1'b0;
                            r_mem_wdata <= '0;
                            r_mem_mask  <= 4'b1111;
                        end
                    end
                end

                S_ISSUE: begin
                    // i_mem_rvalid is deliberately ignored here.
                    if (bus.i_mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_cnt     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                        r_last_d  <= r_win_d;
`endif
                        if (r_mem_wen) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end

                S_WAIT: begin
                    if (bus.i_mem_rvalid) begin
                        if (r_win_d) begin
                            r_d_rdata  <= bus.i_mem_rdata;
                            r_d_rvalid <= 1'b1;
                        end else begin
                            r_if_rdata  <= bus.i_mem_rdata;
                            r_if_rvalid <= 1'b1;
                        end
                        r_state <= S_RESP;
                    end else if ((TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
                        // Abandon the read: flag it and free the port without
                        // producing any rvalid.
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_RESP: begin
                    // New arbitration only starts once back in IDLE.
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_if_gnt    = w_accept & ~r_win_d;
    assign bus.o_d_gnt     = w_accept &  r_win_d;
    assign bus.o_if_rvalid = r_if_rvalid;
    assign bus.o_if_rdata  = r_if_rdata;
    assign bus.o_d_rvalid  = r_d_rvalid;
    assign bus.o_d_rdata   = r_d_rdata;
    assign bus.o_mem_req   = r_mem_req;
    assign bus.o_mem_addr  = r_mem_addr;
    assign bus.o_mem_ren   = r_mem_ren;
    assign bus.o_mem_wen   = r_mem_wen;
    assign bus.o_mem_wdata = r_mem_wdata;
    assign bus.o_mem_mask  = r_mem_mask;
    assign bus.o_err       = r_err;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed steps followed by a randomized phase. The reference model works at
// transaction level: who should win, what the memory port must show, which
// requester gets the response and with what data. Inputs are driven 1ns after
// the rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int TIMEOUT = 16;

    // ---------------------------------------------------------------- clock/reset
    logic       i_clk;
    logic       i_rst;
    logic [1:0] dbg_state;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------------------------------------------------------- model state
    int          n_vec;
    int          n_err;
    bit          m_err;
    bit          m_last_d;
    logic [31:0] m_if_rdata;
    logic [31:0] m_d_rdata;
    logic [31:0] exp_q[$];

    // ---------------------------------------------------------------- checks
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    // ---------------------------------------------------------------- drivers
    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge i_clk);
    endtask

    task automatic clear_inputs();
        bus.i_if_req     = 1'b0;
        bus.i_if_addr    = '0;
        bus.i_d_req      = 1'b0;
        bus.i_d_addr     = '0;
        bus.i_d_ren      = 1'b0;
        bus.i_d_wen      = 1'b0;
        bus.i_d_wdata    = '0;
        bus.i_d_mask     = '0;
        bus.i_mem_ready  = 1'b0;
        bus.i_mem_rvalid = 1'b0;
        bus.i_mem_rdata  = '0;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        clear_inputs();
        next_cycle();
        i_rst      = 1'b0;
        m_err      = 1'b0;
        m_last_d   = 1'b0;
        m_if_rdata = '0;
        m_d_rdata  = '0;
        exp_q.delete();
    endtask

    task automatic set_d(input logic ren, input logic wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] mask);
        bus.i_d_req   = 1'b1;
        bus.i_d_ren   = ren;
        bus.i_d_wen   = wen;
        bus.i_d_addr  = addr;
        bus.i_d_wdata = wdata;
        bus.i_d_mask  = mask;
    endtask

    task automatic set_if(input logic [31:0] addr);
        bus.i_if_req  = 1'b1;
        bus.i_if_addr = addr;
    endtask

    // Checks every output that is fully defined between transactions.
    task automatic chk_all_zero(input string pfx);
        chk_b({pfx, "_mem_req"},   bus.o_mem_req,   1'b0);
        chk  ({pfx, "_mem_addr"},  bus.o_mem_addr,  32'h0);
        chk_b({pfx, "_mem_ren"},   bus.o_mem_ren,   1'b0);
        chk_b({pfx, "_mem_wen"},   bus.o_mem_wen,   1'b0);
        chk  ({pfx, "_mem_wdata"}, bus.o_mem_wdata, 32'h0);
        chk  ({pfx, "_mem_mask"},  {28'h0, bus.o_mem_mask}, 32'h0);
        chk_b({pfx, "_if_gnt"},    bus.o_if_gnt,    1'b0);
        chk_b({pfx, "_d_gnt"},     bus.o_d_gnt,     1'b0);
        chk_b({pfx, "_if_rvalid"}, bus.o_if_rvalid, 1'b0);
        chk_b({pfx, "_d_rvalid"},  bus.o_d_rvalid,  1'b0);
        chk  ({pfx, "_if_rdata"},  bus.o_if_rdata,  32'h0);
        chk  ({pfx, "_d_rdata"},   bus.o_d_rdata,   32'h0);
        chk_b({pfx, "_err"},       bus.o_err,       1'b0);
    endtask

    // One complete transaction starting in an IDLE cycle with at least one
    // request already driven. rdy_dly = ISSUE cycles before memory is ready;
    // rv_dly = WAIT cycles before rvalid (>= TIMEOUT means never).
    task automatic do_txn(input int rdy_dly, input int rv_dly, input logic [31:0] rsp);
        bit          wd;
        bit          bad;
        bit          rd;
        bit          got;
        logic [31:0] a;
        logic [3:0]  mk;
        logic [31:0] wdat;
        logic [31:0] rdat;

        // Arbitration rule
        if (bus.i_d_req && bus.i_if_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            wd = !m_last_d;
`else
            wd = 1'b1;
`endif
        end else begin
            wd = bus.i_d_req;
        end

        // What the memory port must carry
        if (wd) begin
            a    = bus.i_d_addr;
            bad  = (bus.i_d_ren && bus.i_d_wen) || (!bus.i_d_ren && !bus.i_d_wen);
            rd   = !(bus.i_d_wen && !bus.i_d_ren);
            mk   = bus.i_d_mask;
            wdat = bus.i_d_wdata;
        end else begin
            a    = bus.i_if_addr;
            bad  = 1'b0;
            rd   = 1'b1;
            mk   = 4'b1111;
            wdat = '0;
        end
        a[1:0] = 2'b00;

        // IDLE cycle
        bus.i_mem_ready  = 1'b0;
        bus.i_mem_rvalid = 1'b0;
        sample();
        chk_b("idle_mem_req",   bus.o_mem_req,   1'b0);
        chk_b("idle_if_gnt",    bus.o_if_gnt,    1'b0);
        chk_b("idle_d_gnt",     bus.o_d_gnt,     1'b0);
        chk_b("idle_if_rvalid", bus.o_if_rvalid, 1'b0);
        chk_b("idle_d_rvalid",  bus.o_d_rvalid,  1'b0);
        chk_b("idle_err",       bus.o_err,       m_err);
        next_cycle();
        if (bad) m_err = 1'b1;

        // ISSUE cycles, with stray rvalids that must be ignored
        for (int k = 0; k <= rdy_dly; k++) begin
            bus.i_mem_ready  = (k == rdy_dly);
            bus.i_mem_rvalid = 1'($urandom_range(0, 1));
            bus.i_mem_rdata  = $urandom;
            sample();
            chk_b("iss_mem_req", bus.o_mem_req, 1'b1);
            chk  ("iss_addr",    bus.o_mem_addr, a);
            chk_b("iss_ren",     bus.o_mem_ren, rd);
            chk_b("iss_wen",     bus.o_mem_wen, !rd);
            chk  ("iss_mask",    {28'h0, bus.o_mem_mask}, {28'h0, mk});
            if (!rd) chk("iss_wdata", bus.o_mem_wdata, wdat);
            chk_b("iss_err",     bus.o_err, m_err);
            chk_b("iss_if_gnt",  bus.o_if_gnt, (k == rdy_dly) && !wd);
            chk_b("iss_d_gnt",   bus.o_d_gnt,  (k == rdy_dly) && wd);
            next_cycle();
            bus.i_mem_ready  = 1'b0;
            bus.i_mem_rvalid = 1'b0;
        end
        if (wd) bus.i_d_req = 1'b0;
        else    bus.i_if_req = 1'b0;
        m_last_d = wd;

        if (!rd) return;

        // WAIT cycles
        got = 1'b0;
        for (int w = 0; w < TIMEOUT; w++) begin
            bus.i_mem_rvalid = (w == rv_dly);
            bus.i_mem_rdata  = (w == rv_dly) ? rsp : $urandom;
            if (w == rv_dly) exp_q.push_back(rsp);
            sample();
            chk_b("wait_mem_req",   bus.o_mem_req,   1'b0);
            chk_b("wait_if_rvalid", bus.o_if_rvalid, 1'b0);
            chk_b("wait_d_rvalid",  bus.o_d_rvalid,  1'b0);
            next_cycle();
            bus.i_mem_rvalid = 1'b0;
            if (w == rv_dly) begin
                got = 1'b1;
                break;
            end
        end

        if (!got) begin
            // Timed out: back in IDLE, a late rvalid must not produce a response.
            m_err = 1'b1;
            bus.i_mem_rvalid = 1'b1;
            bus.i_mem_rdata  = 32'hDEAD_BEEF;
            sample();
            chk_b("to_err",     bus.o_err,     m_err);
            chk_b("to_mem_req", bus.o_mem_req, 1'b0);
            next_cycle();
            bus.i_mem_rvalid = 1'b0;
            sample();
            chk_b("to_if_rvalid", bus.o_if_rvalid, 1'b0);
            chk_b("to_d_rvalid",  bus.o_d_rvalid,  1'b0);
            chk_b("to_mem_req2",  bus.o_mem_req,   1'b0);
            next_cycle();
            return;
        end

        // RESP cycle
        sample();
        rdat = exp_q.pop_front();
        if (wd) begin
            chk_b("resp_d_rvalid",  bus.o_d_rvalid,  1'b1);
            chk  ("resp_d_rdata",   bus.o_d_rdata,   rdat);
            chk_b("resp_if_rvalid", bus.o_if_rvalid, 1'b0);
            chk  ("resp_if_hold",   bus.o_if_rdata,  m_if_rdata);
            m_d_rdata = rdat;
        end else begin
            chk_b("resp_if_rvalid", bus.o_if_rvalid, 1'b1);
            chk  ("resp_if_rdata",  bus.o_if_rdata,  rdat);
            chk_b("resp_d_rvalid",  bus.o_d_rvalid,  1'b0);
            chk  ("resp_d_hold",    bus.o_d_rdata,   m_d_rdata);
            m_if_rdata = rdat;
        end
        chk_b("resp_err", bus.o_err, m_err);
        next_cycle();
    endtask

    // ---------------------------------------------------------------- watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- stimulus
    initial begin
        n_vec = 0;
        n_err = 0;
        i_rst = 1'b1;
        clear_inputs();
        do_reset();
        do_reset();

        // Reset values
        sample();
        chk_all_zero("rst");
        next_cycle();

        // Single fetch
        set_if(32'h0000_0104);
        do_txn(0, 1, 32'h00A0_0093);

        // Store with 3 cycles of backpressure, then IDLE with no response
        set_d(1'b0, 1'b1, 32'h0000_2003, 32'hAB00_0000, 4'b1000);
        do_txn(3, 0, 32'h0);
        sample();
        chk_b("st_idle_mem_req", bus.o_mem_req,   1'b0);
        chk_b("st_if_rvalid",    bus.o_if_rvalid, 1'b0);
        chk_b("st_d_rvalid",     bus.o_d_rvalid,  1'b0);
        next_cycle();

        // Simultaneous requests: data first, then the waiting fetch
        set_d(1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'b1111);
        set_if(32'h0000_0400);
        do_txn(0, 0, $urandom);
        do_txn(1, 2, $urandom);

        // Both requesters kept high across 4 transactions
        for (int i = 0; i < 4; i++) begin
            if (!bus.i_d_req)  set_d(1'b1, 1'b0, 32'h0000_0500 + 32'(i * 4), 32'h0, 4'b0011);
            if (!bus.i_if_req) set_if(32'h0000_0600 + 32'(i * 4));
            do_txn(0, 0, $urandom);
        end
        while (bus.i_d_req || bus.i_if_req) do_txn(0, 0, $urandom);

        // Randomized mix of loads, stores and fetches
        for (int i = 0; i < 40; i++) begin
            if (!bus.i_d_req && $urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 1) == 1)
                    set_d(1'b1, 1'b0, $urandom, $urandom, 4'($urandom_range(1, 15)));
                else
                    set_d(1'b0, 1'b1, $urandom, $urandom, 4'($urandom_range(1, 15)));
            end
            if (!bus.i_if_req && ($urandom_range(0, 1) == 1 || !bus.i_d_req))
                set_if($urandom);
            do_txn($urandom_range(0, 3), $urandom_range(0, 4), $urandom);
        end
        while (bus.i_d_req || bus.i_if_req) do_txn(0, 0, $urandom);

        // Protocol errors: ren=wen=1, then ren=wen=0; both serviced as reads
        set_d(1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678, 4'b1111);
        do_txn(0, 0, 32'h0BAD_0010);
        set_d(1'b0, 1'b0, 32'h0000_0014, 32'h0, 4'b0001);
        do_txn(1, 3, 32'h0BAD_0014);

        // Clear the sticky error, then a read whose response never comes
        do_reset();
        sample();
        chk_b("clr_err", bus.o_err, 1'b0);
        next_cycle();
        set_d(1'b1, 1'b0, 32'h0000_0700, 32'h0, 4'b1111);
        do_txn(0, TIMEOUT - 1, 32'h5555_AAAA);   // last legal WAIT cycle
        set_if(32'h0000_0800);
        do_txn(0, TIMEOUT, 32'h0);               // never answered
        set_if(32'h0000_0804);
        do_txn(0, 0, 32'h1357_9BDF);             // serviced normally, err stays set

        // Reset while in WAIT; a late rvalid must be ignored
        set_if(32'h0000_0900);
        next_cycle();                            // IDLE -> ISSUE
        bus.i_mem_ready = 1'b1;
        next_cycle();                            // accepted -> WAIT
        bus.i_mem_ready = 1'b0;
        bus.i_if_req    = 1'b0;
        next_cycle();                            // WAIT
        do_reset();                              // reset sampled in WAIT
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata  = 32'hCAFE_F00D;
        sample();
        chk_all_zero("wrst");
        next_cycle();
        bus.i_mem_rvalid = 1'b0;
        sample();
        chk_b("wrst_if_rvalid2", bus.o_if_rvalid, 1'b0);
        chk_b("wrst_d_rvalid2",  bus.o_d_rvalid,  1'b0);
        chk_b("wrst_mem_req2",   bus.o_mem_req,   1'b0);
        next_cycle();

        // Normal operation after reset
        set_if(32'h0000_0A00);
        do_txn(0, 0, 32'h2468_ACE0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
